// File: rtl/freq_meter_recip.sv
// rtl/freq_meter_recip.sv - equal-precision (reciprocal) frequency meter with fx/ref gate handshake

// Multi-flop synchroniser for a level that changes slowly relative to the destination clock.
module fm_sync #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] ff;

  // Shift the input through the chain; the last stage is the usable copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// Reset bridge: asserts asynchronously, releases on the local clock.
module fm_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [STAGES-1:0] ff;

  // Ones ripple in after rst_n rises, so release is aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = ff[STAGES-1];

endmodule

module freq_meter_recip #(
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int IDLE_CYCLES    = 1_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk_fx,
  input  logic             rst_n,
  input  logic             clk_ref,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] meas_fx_cnt,
  output logic [CNT_W-1:0] meas_ref_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             overflow
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int MAX_GI = (GATE_CYCLES > IDLE_CYCLES) ? GATE_CYCLES : IDLE_CYCLES;
  localparam int MAX_T  = (MAX_GI > TIMEOUT_CYCLES) ? MAX_GI : TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(MAX_T + 1);

  localparam logic [TMR_W-1:0] GATE_T   = TMR_W'(GATE_CYCLES);
  localparam logic [TMR_W-1:0] IDLE_T   = TMR_W'(IDLE_CYCLES);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_RUN,
    S_CLOSE,
    S_CAPTURE,
    S_HOLDOFF
  } state_t;

  logic             rst_fx_n;
  logic             rst_ref_n;
  logic             gate_req;
  logic             gate_req_fx;
  logic             gate_fx;
  logic             gate_ref;
  logic [CNT_W-1:0] fx_cnt;
  logic             fx_ovf;
  logic             fx_ovf_sync;
  logic [CNT_W-1:0] ref_cnt;
  logic             ref_ovf;
  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             armed;
  logic             tmo_hit;

  fm_rst_sync #(.STAGES(SYNC_N)) u_rst_fx (
    .clk        (clk_fx),
    .rst_n      (rst_n),
    .rst_sync_n (rst_fx_n)
  );

  fm_rst_sync #(.STAGES(SYNC_N)) u_rst_ref (
    .clk        (clk_ref),
    .rst_n      (rst_n),
    .rst_sync_n (rst_ref_n)
  );

  fm_sync #(.STAGES(SYNC_N), .W(1)) u_req_sync (
    .clk   (clk_fx),
    .rst_n (rst_fx_n),
    .d     (gate_req),
    .q     (gate_req_fx)
  );

  fm_sync #(.STAGES(SYNC_N), .W(2)) u_gate_sync (
    .clk   (clk_ref),
    .rst_n (rst_ref_n),
    .d     ({gate_fx, fx_ovf}),
    .q     ({gate_ref, fx_ovf_sync})
  );

  // fx domain: gate opens and closes on clk_fx edges; the close edge completes the last period.
  always_ff @(posedge clk_fx or negedge rst_fx_n) begin
    if (!rst_fx_n) begin
      gate_fx <= 1'b0;
      fx_cnt  <= '0;
      fx_ovf  <= 1'b0;
    end else if (!gate_fx) begin
      if (gate_req_fx) begin
        gate_fx <= 1'b1;
        fx_cnt  <= '0;
        fx_ovf  <= 1'b0;
      end
    end else begin
      if (fx_cnt == CNT_MAX) begin
        fx_ovf <= 1'b1;
      end else begin
        fx_cnt <= fx_cnt + CNT_ONE;
      end
      if (!gate_req_fx) begin
        gate_fx <= 1'b0;
      end
    end
  end

  // ref domain: count reference cycles seen inside the synchronised gate.
  always_ff @(posedge clk_ref or negedge rst_ref_n) begin
    if (!rst_ref_n) begin
      ref_cnt <= '0;
      ref_ovf <= 1'b0;
    end else if (state == S_OPEN && !armed) begin
      ref_cnt <= '0;
      ref_ovf <= 1'b0;
    end else if (gate_ref) begin
      if (ref_cnt == CNT_MAX) begin
        ref_ovf <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + CNT_ONE;
      end
    end
  end

  // Measurement sequencer; OPEN only raises gate_req once a stale gate has been seen low.
  always_ff @(posedge clk_ref or negedge rst_ref_n) begin
    if (!rst_ref_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      armed        <= 1'b0;
      tmo_hit      <= 1'b0;
      gate_req     <= 1'b0;
      busy         <= 1'b0;
      meas_fx_cnt  <= '0;
      meas_ref_cnt <= '0;
      meas_valid   <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          gate_req <= 1'b0;
          if (start || cont) begin
            state   <= S_OPEN;
            busy    <= 1'b1;
            timer   <= TMR_ONE;
            armed   <= 1'b0;
            tmo_hit <= 1'b0;
          end
        end
        S_OPEN: begin
          if (!armed && !gate_ref) begin
            armed    <= 1'b1;
            gate_req <= 1'b1;
          end
          if (armed && gate_ref) begin
            state <= S_RUN;
            timer <= TMR_ONE;
          end else if (timer >= TMO_LAST) begin
            state    <= S_CAPTURE;
            tmo_hit  <= 1'b1;
            gate_req <= 1'b0;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        S_RUN: begin
          if (timer == GATE_T) begin
            state    <= S_CLOSE;
            gate_req <= 1'b0;
            timer    <= TMR_ONE;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        S_CLOSE: begin
          if (!gate_ref) begin
            state <= S_CAPTURE;
          end else if (timer >= TMO_LAST) begin
            state   <= S_CAPTURE;
            tmo_hit <= 1'b1;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        S_CAPTURE: begin
          meas_valid <= 1'b1;
          timeout    <= tmo_hit;
          gate_req   <= 1'b0;
          if (tmo_hit) begin
            meas_fx_cnt  <= '0;
            meas_ref_cnt <= '0;
            overflow     <= 1'b0;
          end else begin
            // fx_cnt has been static since gate_fx fell, well before gate_ref followed it.
            meas_fx_cnt  <= fx_cnt;
            meas_ref_cnt <= ref_cnt;
            overflow     <= fx_ovf_sync | ref_ovf;
          end
          if (cont) begin
            state <= S_HOLDOFF;
            timer <= TMR_ONE;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HOLDOFF: begin
          if (!cont) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (timer >= IDLE_T && !gate_ref) begin
            state   <= S_OPEN;
            timer   <= TMR_ONE;
            armed   <= 1'b0;
            tmo_hit <= 1'b0;
          end else if (timer < IDLE_T) begin
            timer <= timer + TMR_ONE;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          gate_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_recip.sv
// tb/tb_freq_meter_recip.sv - scoreboard bench for freq_meter_recip
`timescale 1ns/1ps
module tb_freq_meter_recip;

  localparam real T_REF = 20.0;

  typedef struct {
    bit  tmo;
    bit  ovf;
    bit  exact;
    int  exp_fx;
    int  exp_ref;
    real tfx;
    int  min_fx;
    int  min_ref;
  } exp_t;

  logic        clk_ref = 1'b0;
  logic        clk_fx  = 1'b0;
  logic        clk_fx8 = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        cont    = 1'b0;
  logic        start8  = 1'b0;
  logic        cont8   = 1'b0;
  logic        fx_run  = 1'b1;
  real         fx_half = 50.0;

  logic        busy, meas_valid, timeout, overflow;
  logic [31:0] meas_fx_cnt, meas_ref_cnt;
  logic        busy8, valid8, tmo8, ovf8;
  logic [7:0]  fx8, ref8;

  exp_t sb[$];
  exp_t sb8[$];
  int   vstamp[$];
  int   n_valid  = 0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  freq_meter_recip #(
    .CNT_W(32), .GATE_CYCLES(1000), .IDLE_CYCLES(100), .TIMEOUT_CYCLES(500), .SYNC_STAGES(2)
  ) dut (
    .clk_fx(clk_fx), .rst_n(rst_n), .clk_ref(clk_ref), .start(start), .cont(cont),
    .busy(busy), .meas_fx_cnt(meas_fx_cnt), .meas_ref_cnt(meas_ref_cnt),
    .meas_valid(meas_valid), .timeout(timeout), .overflow(overflow)
  );

  freq_meter_recip #(
    .CNT_W(8), .GATE_CYCLES(300), .IDLE_CYCLES(100), .TIMEOUT_CYCLES(500), .SYNC_STAGES(2)
  ) dut8 (
    .clk_fx(clk_fx8), .rst_n(rst_n), .clk_ref(clk_ref), .start(start8), .cont(cont8),
    .busy(busy8), .meas_fx_cnt(fx8), .meas_ref_cnt(ref8),
    .meas_valid(valid8), .timeout(tmo8), .overflow(ovf8)
  );

  always #(T_REF / 2.0) clk_ref = ~clk_ref;

  initial begin
    #3.3;
    forever begin
      #(fx_half);
      if (fx_run) clk_fx = ~clk_fx;
      else clk_fx = 1'b0;
    end
  end

  initial begin
    #7;
    forever #10 clk_fx8 = ~clk_fx8;
  end

  always @(posedge clk_ref) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic exp_t mk_ratio(input real tfx, input int min_fx);
    exp_t e;
    e.tmo = 1'b0; e.ovf = 1'b0; e.exact = 1'b0;
    e.exp_fx = 0; e.exp_ref = 0;
    e.tfx = tfx; e.min_fx = min_fx; e.min_ref = 1000;
    return e;
  endfunction

  function automatic exp_t mk_exact(input bit tmo, input bit ovf, input int fx, input int rf);
    exp_t e;
    e.tmo = tmo; e.ovf = ovf; e.exact = 1'b1;
    e.exp_fx = fx; e.exp_ref = rf;
    e.tfx = 0.0; e.min_fx = 0; e.min_ref = 0;
    return e;
  endfunction

  task automatic check_result(input string who, input exp_t e, input longint fx,
                              input longint rf, input logic tmo, input logic ovf);
    real err;
    check({who, "_timeout"}, tmo, e.tmo);
    check({who, "_overflow"}, ovf, e.ovf);
    if (e.exact) begin
      check({who, "_fx_cnt"}, fx, e.exp_fx);
      check({who, "_ref_cnt"}, rf, e.exp_ref);
    end else begin
      err = real'(rf) * T_REF - real'(fx) * e.tfx;
      check({who, "_fx_min"}, (fx >= e.min_fx), 1);
      check({who, "_ref_min"}, (rf >= e.min_ref), 1);
      if (!(err <= T_REF && err >= -T_REF))
        $display("ratio detail %s: fx=%0d ref=%0d err_ns=%0.3f", who, fx, rf, err);
      check({who, "_ratio"}, (err <= T_REF && err >= -T_REF), 1);
    end
  endtask

  // Scoreboard for the 32-bit meter.
  always @(negedge clk_ref) begin
    if (meas_valid) begin
      n_valid++;
      vstamp.push_back(cyc);
      if (sb.size() == 0) begin
        check("main_unexpected_valid", 1, 0);
      end else begin
        check_result("main", sb.pop_front(), meas_fx_cnt, meas_ref_cnt, timeout, overflow);
      end
    end
  end

  // Scoreboard for the 8-bit meter.
  always @(negedge clk_ref) begin
    if (valid8) begin
      if (sb8.size() == 0) begin
        check("dut8_unexpected_valid", 1, 0);
      end else begin
        check_result("dut8", sb8.pop_front(), fx8, ref8, tmo8, ovf8);
      end
    end
  end

  task automatic pulse_start(output int t_busy);
    @(negedge clk_ref);
    start = 1'b1;
    @(negedge clk_ref);
    start = 1'b0;
    t_busy = cyc;
  endtask

  task automatic wait_done(input string tag, input bit need_idle);
    int k;
    k = 0;
    while ((sb.size() != 0 || (need_idle && busy)) && k < 6000) begin
      @(negedge clk_ref);
      k++;
    end
    if (k >= 6000) check({tag, "_wait_bound"}, 0, 1);
  endtask

  task automatic check_latency(input string tag, input int t_busy, input int exp_lat);
    if (vstamp.size() == 0) check(tag, -1, exp_lat);
    else check(tag, vstamp[vstamp.size() - 1] - t_busy, exp_lat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tb_;
    int n0;
    int k;

    repeat (5) @(negedge clk_ref);
    check("rst_busy", busy, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_meas_fx_cnt", meas_fx_cnt, 0);
    check("rst_meas_ref_cnt", meas_ref_cnt, 0);
    check("rst_timeout", timeout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_gate_fx", dut.gate_fx, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_ref);

    // Single shot at 10 MHz against a 50 MHz reference.
    n0 = n_valid;
    sb.push_back(mk_ratio(2.0 * fx_half, 200));
    pulse_start(tb_);
    wait_done("t1", 1'b1);
    check("t1_valid_count", n_valid - n0, 1);
    check("t1_busy_after", busy, 0);

    // Continuous mode at ~7 MHz: three results, then drop cont.
    fx_half = 71.4285714;
    repeat (10) @(negedge clk_ref);
    vstamp.delete();
    n0 = n_valid;
    for (int i = 0; i < 3; i++) sb.push_back(mk_ratio(2.0 * fx_half, 140));
    cont = 1'b1;
    wait_done("t2", 1'b0);
    cont = 1'b0;
    wait_done("t2_stop", 1'b1);
    check("t2_valid_count", n_valid - n0, 3);
    for (int i = 1; i < vstamp.size(); i++)
      check("t2_gap", (vstamp[i] - vstamp[i - 1] >= 1100), 1);

    // Dead input: timeout exactly 500 cycles after OPEN entry, then recovery.
    fx_half = 50.0;
    fx_run  = 1'b0;
    repeat (10) @(negedge clk_ref);
    vstamp.delete();
    sb.push_back(mk_exact(1'b1, 1'b0, 0, 0));
    pulse_start(tb_);
    wait_done("t3_tmo", 1'b1);
    check_latency("t3_tmo_latency", tb_, 500);
    fx_run = 1'b1;
    repeat (20) @(negedge clk_ref);
    sb.push_back(mk_ratio(2.0 * fx_half, 200));
    pulse_start(tb_);
    wait_done("t3_recover", 1'b1);

    // 8-bit meter with f_fx == f_ref saturates both counters.
    sb8.push_back(mk_exact(1'b0, 1'b1, 255, 255));
    @(negedge clk_ref);
    start8 = 1'b1;
    @(negedge clk_ref);
    start8 = 1'b0;
    k = 0;
    while ((sb8.size() != 0 || busy8) && k < 6000) begin
      @(negedge clk_ref);
      k++;
    end
    if (k >= 6000) check("t4_wait_bound", 0, 1);

    // Asynchronous reset in the middle of RUN.
    sb.push_back(mk_ratio(2.0 * fx_half, 200));
    pulse_start(tb_);
    repeat (300) @(negedge clk_ref);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("t5_busy", busy, 0);
    check("t5_meas_valid", meas_valid, 0);
    check("t5_meas_fx_cnt", meas_fx_cnt, 0);
    check("t5_meas_ref_cnt", meas_ref_cnt, 0);
    check("t5_timeout", timeout, 0);
    check("t5_overflow", overflow, 0);
    check("t5_gate_fx", dut.gate_fx, 0);
    check("t5_state_idle", dut.state, 0);
    @(negedge clk_ref);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_ref);
    sb.push_back(mk_ratio(2.0 * fx_half, 200));
    pulse_start(tb_);
    wait_done("t5_after", 1'b1);

    // Extra start pulses while busy are ignored.
    n0 = n_valid;
    sb.push_back(mk_ratio(2.0 * fx_half, 200));
    pulse_start(tb_);
    repeat (200) @(negedge clk_ref);
    for (int i = 0; i < 3; i++) begin
      pulse_start(tb_);
      repeat (50) @(negedge clk_ref);
    end
    wait_done("t6_extra", 1'b1);
    check("t6_valid_count", n_valid - n0, 1);

    // clk_fx dies mid-RUN: CLOSE times out with the gate stuck high.
    sb.push_back(mk_exact(1'b1, 1'b0, 0, 0));
    pulse_start(tb_);
    repeat (400) @(negedge clk_ref);
    fx_run = 1'b0;
    wait_done("t6_close_tmo", 1'b1);

    // Stuck gate must not be reused: next OPEN times out after 500, not via RUN.
    vstamp.delete();
    sb.push_back(mk_exact(1'b1, 1'b0, 0, 0));
    pulse_start(tb_);
    wait_done("t6_stuck", 1'b1);
    check_latency("t6_stuck_latency", tb_, 500);

    fx_run = 1'b1;
    repeat (20) @(negedge clk_ref);
    sb.push_back(mk_ratio(2.0 * fx_half, 200));
    pulse_start(tb_);
    wait_done("t6_recover", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
